// File: rtl/alu_exec_unit.sv
// Handshaked 32-bit ALU. Most operations complete in a single step.
// Shifts by n>0 run through a 1-bit-per-cycle shifter for n cycles.
module alu_exec_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  ALUOp,
    input  logic        Sign,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow
);
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOR = 4'd5;
    localparam logic [3:0] OP_SL  = 4'd6;
    localparam logic [3:0] OP_SR  = 4'd7;
    localparam logic [3:0] OP_LT  = 4'd8;
    localparam logic [3:0] OP_LE  = 4'd9;
    localparam logic [3:0] OP_GT  = 4'd10;

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

    state_t      state;
    logic [31:0] shift_data;
    logic [31:0] shift_step;
    logic [4:0]  count;
    logic        shift_left;
    logic        shift_fill;
    logic [31:0] calc;
    logic        calc_ovf;
    logic [31:0] sum;
    logic [31:0] diff;
    logic        lt;
    logic        eq;
    logic        accept;
    logic        start_shift;

    assign in_ready    = (state == IDLE) || (state == DONE && out_ready);
    assign accept      = in_valid && in_ready;
    assign start_shift = (ALUOp == OP_SL || ALUOp == OP_SR) && (in_a[4:0] != 5'd0);

    assign sum  = in_a + in_b;
    assign diff = in_a - in_b;
    assign lt   = Sign ? ($signed(in_a) < $signed(in_b)) : (in_a < in_b);
    assign eq   = (in_a == in_b);

    // Fill bit for right shifts is captured at accept so it stays the original B[31].
    assign shift_step = shift_left ? {shift_data[30:0], 1'b0}
                                   : {shift_fill, shift_data[31:1]};

    always_comb begin
        calc     = 32'd0;
        calc_ovf = 1'b0;
        case (ALUOp)
            OP_ADD: begin
                calc     = sum;
                calc_ovf = Sign && (in_a[31] == in_b[31]) && (sum[31] != in_a[31]);
            end
            OP_SUB: begin
                calc     = diff;
                calc_ovf = Sign && (in_a[31] != in_b[31]) && (diff[31] != in_a[31]);
            end
            OP_AND:  calc = in_a & in_b;
            OP_OR:   calc = in_a | in_b;
            OP_XOR:  calc = in_a ^ in_b;
            OP_NOR:  calc = ~(in_a | in_b);
            OP_SL,
            OP_SR:   calc = in_b;
            OP_LT:   calc = {31'd0, lt};
            OP_LE:   calc = {31'd0, lt || eq};
            OP_GT:   calc = {31'd0, !(lt || eq)};
            default: calc = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            result     <= 32'd0;
            zero       <= 1'b0;
            overflow   <= 1'b0;
            count      <= 5'd0;
            shift_data <= 32'd0;
            shift_left <= 1'b0;
            shift_fill <= 1'b0;
        end else if (state == SHIFT) begin
            shift_data <= shift_step;
            count      <= count - 5'd1;
            if (count == 5'd1) begin
                result    <= shift_step;
                zero      <= (shift_step == 32'd0);
                overflow  <= 1'b0;
                out_valid <= 1'b1;
                state     <= DONE;
            end
        end else if (accept) begin
            if (start_shift) begin
                shift_data <= in_b;
                count      <= in_a[4:0];
                shift_left <= (ALUOp == OP_SL);
                shift_fill <= Sign && in_b[31];
                out_valid  <= 1'b0;
                state      <= SHIFT;
            end else begin
                result    <= calc;
                zero      <= (calc == 32'd0);
                overflow  <= calc_ovf;
                out_valid <= 1'b1;
                state     <= DONE;
            end
        end else if (state == DONE && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: random traffic against a transaction-level model,
// plus directed cases with hand-computed results.
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  ALUOp = 4'd0;
    logic        Sign = 1'b0;
    logic [31:0] in_a = 32'd0;
    logic [31:0] in_b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero;
    logic        overflow;

    alu_exec_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .Sign(Sign), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: one pending operation that becomes visible at cycle ready_cyc
    // and stays visible until the consumer takes it.
    bit          pend = 1'b0;
    int          cyc = 0;
    int          ready_cyc = 0;
    logic [31:0] m_res = 32'd0;
    logic        m_ovf = 1'b0;

    function automatic logic [32:0] ref_op(input logic [3:0] op, input logic s,
                                           input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, wide;
        logic [31:0] r;
        logic o;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        r = 32'd0;
        o = 1'b0;
        case (op)
            4'd0: begin
                r = a + b;
                wide = sa + sb;
                o = s && (wide > 64'sd2147483647 || wide < -64'sd2147483648);
            end
            4'd1: begin
                r = a - b;
                wide = sa - sb;
                o = s && (wide > 64'sd2147483647 || wide < -64'sd2147483648);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~(a | b);
            4'd6: r = b << a[4:0];
            4'd7: r = s ? 32'($signed(b) >>> a[4:0]) : (b >> a[4:0]);
            4'd8: r = {31'd0, sa < sb};
            4'd9: r = {31'd0, sa <= sb};
            4'd10: r = {31'd0, sa > sb};
            default: r = 32'd0;
        endcase
        return {o, r};
    endfunction

    function automatic bit model_valid();
        return pend && (cyc >= ready_cyc);
    endfunction

    function automatic bit model_ready();
        return !pend || (model_valid() && out_ready);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend = 1'b0;
        end else begin
            bit acc, take;
            logic [32:0] r;
            acc  = in_valid && model_ready();
            take = model_valid() && out_ready;
            cyc++;
            if (acc) begin
                r = ref_op(ALUOp, Sign, in_a, in_b);
                m_res = r[31:0];
                m_ovf = r[32];
                pend = 1'b1;
                ready_cyc = cyc + (((ALUOp == 4'd6) || (ALUOp == 4'd7)) ? int'(in_a[4:0]) : 0);
            end else if (take) begin
                pend = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", {31'd0, in_ready}, {31'd0, model_ready()});
        chk("out_valid", {31'd0, out_valid}, {31'd0, model_valid()});
        if (model_valid()) begin
            chk("result", result, m_res);
            chk("zero", {31'd0, zero}, {31'd0, m_res == 32'd0});
            chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        end
    end

    task automatic directed(input string name, input logic [3:0] op, input logic s,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_r, input logic exp_z, input logic exp_o,
                            input int exp_edges);
        int edges;
        @(negedge clk); #1;
        ALUOp = op; Sign = s; in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 0;
        while (out_valid !== 1'b1 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        chk({name, "_edges"}, edges, exp_edges);
        chk({name, "_result"}, result, exp_r);
        chk({name, "_zero"}, {31'd0, zero}, {31'd0, exp_z});
        chk({name, "_overflow"}, {31'd0, overflow}, {31'd0, exp_o});
        $display("directed %s op=%0d sign=%0d a=%h b=%h -> result=%h zero=%0d ovf=%0d after %0d edges",
                 name, op, s, a, b, result, zero, overflow, edges);
        @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 reset = 1'b0;
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_zero", {31'd0, zero}, 32'd0);
        chk("reset_overflow", {31'd0, overflow}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

        directed("add_ovf",  4'd0,  1'b1, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1, 0);
        directed("sub_ovf",  4'd1,  1'b1, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0, 1'b1, 0);
        directed("sr_sign",  4'd7,  1'b1, 32'd4, 32'hF0000000, 32'hFF000000, 1'b0, 1'b0, 4);
        directed("sr_uns",   4'd7,  1'b0, 32'd4, 32'hF0000000, 32'h0F000000, 1'b0, 1'b0, 4);
        directed("sl_zero",  4'd6,  1'b0, 32'd0, 32'h0000ABCD, 32'h0000ABCD, 1'b0, 1'b0, 0);
        directed("lt_sign",  4'd8,  1'b1, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0, 0);
        directed("lt_uns",   4'd8,  1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0, 0);
        directed("gt_sign",  4'd10, 1'b1, 32'd5, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 0);
        directed("le_eq",    4'd9,  1'b0, 32'd5, 32'd5, 32'h1, 1'b0, 1'b0, 0);
        directed("op12",     4'd12, 1'b1, 32'h12345678, 32'h7FFFFFFF, 32'h0, 1'b1, 1'b0, 0);

        // Result held while the consumer stalls, then back-to-back accept.
        @(negedge clk); #1;
        ALUOp = 4'd1; Sign = 1'b0; in_a = 32'd5; in_b = 32'd5; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_result", result, 32'd0);
            chk("hold_zero", {31'd0, zero}, 32'd1);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        ALUOp = 4'd0; in_a = 32'd2; in_b = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
        #1 chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_result", result, 32'd5);
        chk("b2b_zero", {31'd0, zero}, 32'd0);
        $display("directed sub_hold then add 2+3 -> result=%h valid=%0d", result, out_valid);
        @(posedge clk);

        // Reset asserted in the middle of a 31-step shift.
        @(negedge clk); #1;
        ALUOp = 4'd6; Sign = 1'b0; in_a = 32'd31; in_b = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_result", result, 32'd0);
        chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_rel_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_rel_valid", {31'd0, out_valid}, 32'd0);
        repeat (40) @(posedge clk);
        #1 chk("rst_no_stale", {31'd0, out_valid}, 32'd0);
        $display("directed sl31 reset mid-shift -> out_valid=%0d in_ready=%0d", out_valid, in_ready);

        // Random traffic; the negedge compare process checks every cycle.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk); #1;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            ALUOp     = 4'($urandom_range(0, 15));
            Sign      = 1'($urandom_range(0, 1));
            in_a      = $urandom;
            in_b      = $urandom;
            case ($urandom_range(0, 5))
                0: in_b = in_a;
                1: in_a[4:0] = 5'($urandom_range(0, 3));
                2: in_a = 32'h7FFFFFFF;
                3: in_b = 32'h80000000;
                default: ;
            endcase
            if (in_valid && model_ready())
                $display("txn %0d op=%0d sign=%0d a=%h b=%h", i, ALUOp, Sign, in_a, in_b);
        end
        @(negedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1 chk("drain_idle", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
